// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF  = 4;
    localparam int unsigned DW_DEF       = 8;
    localparam int unsigned GAP_CYC_DEF  = 16;
    localparam int unsigned HOLD_TMO_DEF = 8192;
    localparam int unsigned GRANT_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_ACK,
        ST_DRAIN,
        ST_HOLD,
        ST_GAP
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned PW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PW-1:0]      rr_ptr,
    output logic [PW-1:0]      owner,
    output logic               any_req
);

    logic [NUM_REQ-1:0] rot;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        rot     = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
        owner   = rr_ptr;
        any_req = |req_valid;
        // Walk downwards so the lowest rotated position wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                owner = PW'((int'(rr_ptr) + k) % int'(NUM_REQ));
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locked arbiter sharing one uart_tx among NUM_REQ byte producers.
// rst_n is asserted asynchronously and released synchronously by the reset controller in uart_top.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned GAP_CYC  = GAP_CYC_DEF,
    parameter int unsigned HOLD_TMO = HOLD_TMO_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  tx_start,
    output logic [DW-1:0]         tx_data,
    input  logic                  tx_busy,
    output logic [GRANT_W-1:0]    grant_id,
    output logic                  frame_act,
    output logic                  err_abort
);

    localparam int unsigned PW      = idx_width(NUM_REQ);
    localparam int unsigned CNT_MAX = (HOLD_TMO > GAP_CYC) ? HOLD_TMO : GAP_CYC;
    localparam int unsigned CW      = idx_width(CNT_MAX);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TMO - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);
    localparam state_t        POST_FRAME = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;

    state_t        state, state_d;
    logic [PW-1:0] owner, owner_d;
    logic [PW-1:0] rr_ptr, rr_d;
    logic [PW-1:0] pick_owner, next_ptr;
    logic [CW-1:0] cnt, cnt_d;
    logic          pick_any;
    logic          frame_d;
    logic          last_q;

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .owner     (pick_owner),
        .any_req   (pick_any)
    );

    assign next_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;
    assign grant_id = GRANT_W'(owner);

    // One counter serves both HOLD timeout and GAP; the two states never overlap.
    always_comb begin
        state_d   = state;
        owner_d   = owner;
        rr_d      = rr_ptr;
        cnt_d     = cnt;
        frame_d   = frame_act;
        req_ready = '0;
        tx_start  = 1'b0;
        err_abort = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d = pick_owner;
                    frame_d = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                req_ready[owner] = 1'b1;
                state_d          = ST_START;
            end
            ST_START: begin
                tx_start = 1'b1;
                state_d  = ST_ACK;
            end
            ST_ACK: begin
                if (tx_busy) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        rr_d    = next_ptr;
                        frame_d = 1'b0;
                        cnt_d   = '0;
                        state_d = POST_FRAME;
                    end else if (req_valid[owner]) begin
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (req_valid[owner]) begin
                    state_d = ST_LOAD;
                end else if (cnt == HOLD_LAST) begin
                    err_abort = 1'b1;
                    rr_d      = next_ptr;
                    frame_d   = 1'b0;
                    cnt_d     = '0;
                    state_d   = POST_FRAME;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            frame_act <= 1'b0;
            last_q    <= 1'b0;
            tx_data   <= '0;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            rr_ptr    <= rr_d;
            cnt       <= cnt_d;
            frame_act <= frame_d;
            if (state == ST_LOAD) begin
                tx_data <= req_data[owner*DW +: DW];
                last_q  <= req_last[owner];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx busy model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DW       = 8;
    localparam int GAP_CYC  = 16;
    localparam int HOLD_TMO = 8192;
    localparam int BYTE_CYC = 4340;
    // Cycles from the first busy-low cycle to the next tx_start.
    localparam int GAP_IN_FRAME   = 2;            // DRAIN, LOAD, START
    localparam int GAP_NEXT_FRAME = GAP_CYC + 3;  // DRAIN, GAP x GAP_CYC, IDLE, LOAD, START

    logic                  clk       = 1'b0;
    logic                  rst_n     = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_last  = '0;
    logic [NUM_REQ*DW-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  tx_start;
    logic [DW-1:0]         tx_data;
    logic                  tx_busy;
    logic [2:0]            grant_id;
    logic                  frame_act;
    logic                  err_abort;

    typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { int id; logic [DW-1:0] data; int gap; } exp_t;

    beat_t src_q [NUM_REQ][$];
    exp_t  sb[$];

    int n_vec        = 0;
    int n_err        = 0;
    int cyc          = 0;
    int fall_cyc     = 0;
    int valid3_cyc   = 0;
    int abort_cnt    = 0;
    int exp_abort_id = 0;
    int busy_cnt     = 0;
    int ready_cnt [NUM_REQ];
    logic prev_busy = 1'b0;
    bit   lat_mode  = 1'b0;
    logic [NUM_REQ-1:0] ready_seen = '0;

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DW       (DW),
        .GAP_CYC  (GAP_CYC),
        .HOLD_TMO (HOLD_TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .frame_act (frame_act),
        .err_abort (err_abort)
    );

    always #5 clk = ~clk;

    // uart_tx model: busy rises the cycle after tx_start and stays high BYTE_CYC cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_start) begin
            tx_busy  <= 1'b1;
            busy_cnt <= BYTE_CYC;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) tx_busy <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Monitor first (outputs of this cycle), then producer drivers for the coming edge.
    always @(negedge clk) begin
        exp_t e;
        logic old_v3;
        cyc++;
        if (prev_busy && !tx_busy) fall_cyc = cyc;
        prev_busy = tx_busy;

        if (req_ready != '0) begin
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) ready_cnt[i]++;
            check("ready_vec", 32'(req_ready), (sb.size() > 0) ? (32'd1 << sb[0].id) : 32'd0);
            if (lat_mode) check("lat_ready", cyc - valid3_cyc, 1);
        end

        if (tx_start) begin
            if (sb.size() == 0) begin
                check("unexpected_start", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                check("tx_data", 32'(tx_data), 32'(e.data));
                check("grant_id", 32'(grant_id), e.id);
                check("frame_act_tx", 32'(frame_act), 1);
                if (e.gap > 0) check("start_gap", cyc - fall_cyc, e.gap);
                if (lat_mode) check("lat_start", cyc - valid3_cyc, 2);
            end
        end

        if (err_abort) begin
            abort_cnt++;
            check("abort_delay", cyc - fall_cyc, HOLD_TMO);
            check("abort_id", 32'(grant_id), exp_abort_id);
        end

        old_v3 = req_valid[3];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ready_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            ready_seen[i] = req_ready[i];
            if (src_q[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = src_q[i][0].data;
                req_last[i]           = src_q[i][0].last;
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
        if (!old_v3 && req_valid[3]) valid3_cyc = cyc;
    end

    // Bytes are queued in the order the arbiter is expected to serve them.
    task automatic send(input int id, input logic [DW-1:0] data, input logic last, input int gap);
        exp_t e;
        src_q[id].push_back('{data: data, last: last});
        e.id   = id;
        e.data = data;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_frame_act", 32'(frame_act), 0);
        check("rst_err_abort", 32'(err_abort), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        sb.delete();
        ready_seen = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit done = 1'b0;
        for (int n = 0; n < limit && !done; n++) begin
            @(posedge clk);
            #2;
            done = (sb.size() == 0) && !frame_act && !tx_busy && src_empty();
        end
        check(tag, 32'(done), 1);
        repeat (GAP_CYC + 4) @(posedge clk);
        #2;
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < NUM_REQ; i++) ready_cnt[i] = 0;
        apply_reset();

        // Single two-byte frame from requester 0.
        send(0, 8'h5A, 1'b0, 0);
        send(0, 8'hA5, 1'b1, GAP_IN_FRAME);
        wait_done("t1_done", 3 * BYTE_CYC);
        check("t1_ready0_pulses", ready_cnt[0], 2);
        check("t1_frame_act", 32'(frame_act), 0);

        // All four requesters at once from reset.
        apply_reset();
        send(0, 8'h11, 1'b1, 0);
        send(1, 8'h22, 1'b1, GAP_NEXT_FRAME);
        send(2, 8'h33, 1'b1, GAP_NEXT_FRAME);
        send(3, 8'h44, 1'b1, GAP_NEXT_FRAME);
        wait_done("t2_done", 5 * BYTE_CYC);

        // Frame lock: requester 2 waits for requester 1's whole frame.
        send(1, 8'h31, 1'b0, 0);
        send(1, 8'h32, 1'b0, GAP_IN_FRAME);
        send(1, 8'h33, 1'b1, GAP_IN_FRAME);
        send(2, 8'h3C, 1'b1, GAP_NEXT_FRAME);
        wait_done("t3_done", 5 * BYTE_CYC);

        // Owner 3 stalls after a non-last byte; abort, then 0 wins over 2.
        exp_abort_id = 3;
        send(3, 8'h66, 1'b0, 0);
        send(0, 8'h77, 1'b1, HOLD_TMO + GAP_NEXT_FRAME);
        send(2, 8'h88, 1'b1, GAP_NEXT_FRAME);
        wait_done("t4_done", HOLD_TMO + 4 * BYTE_CYC);
        check("t4_abort_count", abort_cnt, 1);

        // Latency from valid in IDLE.
        lat_mode = 1'b1;
        send(3, 8'hC3, 1'b1, 0);
        wait_done("t5_done", 2 * BYTE_CYC);
        lat_mode = 1'b0;

        // Reset while draining a byte of requester 2.
        send(2, 8'hD2, 1'b1, 0);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(posedge clk);
            #2;
            seen = tx_busy;
        end
        check("t6_busy_seen", 32'(seen), 1);
        repeat (100) @(posedge clk);
        apply_reset();
        send(0, 8'hE0, 1'b1, 0);
        send(3, 8'hE3, 1'b1, 0);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(posedge clk);
            #2;
            seen = (sb.size() == 1);
        end
        check("t6_first_served", 32'(seen), 1);
        check("t6_frame_act", 32'(frame_act), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
